io_bus_bridge: RTL and testbench
================================

Name: io_bus_bridge

Overview:
- Sits between the MEM pipeline stage and the word-addressed IO memory.
- Decodes the IO address window and drives the IO memory's chip-enable, write-enable, address and write data.
- Returns registered read data to the pipeline.
- Turns byte-enabled partial stores into read-modify-write sequences, and stalls the pipeline while a multi-cycle access is in flight.

Parameters:
- IO_BASE, 32'h0000_4000, base address of the IO window.
- IO_MASK, 32'hFFFF_F000, window mask; hit when (req_addr & IO_MASK) == IO_BASE, i.e. a 4 KB / 1024-word window.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_ce  in  1  MEM stage access request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  store data, already lane-aligned.
- req_be  in  4  byte enables; bit i covers bits [8i+7:8i].
- req_stall  out  1  holds the pipeline; the request stays stable while high.
- req_rdata  out  32  load data to the pipeline.
- io_ce  out  1  IO memory chip enable.
- io_we  out  1  IO memory write enable.
- io_addr  out  32  IO memory address; equals req_addr.
- io_wdata  out  32  IO memory write data.
- io_rdata  in  32  IO memory combinational read data.

Behaviour:
- Reset is asynchronous, active-low. While rst = 0:
  - state = IDLE, rdata_q = 0, merge_q = 0.
  - io_ce = 0, io_we = 0, req_stall = 0, req_rdata = 0, regardless of request inputs.
- Reset mid-operation abandons the access; no write is issued.
- hit = req_ce & ((req_addr & IO_MASK) == IO_BASE).
- States: IDLE, RD_DONE, RMW_WR.
- IDLE, no hit:
  - io_ce = 0, io_we = 0, req_stall = 0, req_rdata = 0.
  - Stay IDLE. Out-of-window accesses are ignored entirely.
- IDLE, hit, load:
  - io_ce = 1, io_we = 0, req_stall = 1.
  - At posedge, rdata_q <= io_rdata; go to RD_DONE.
- RD_DONE:
  - req_stall = 0, req_rdata = rdata_q, io_ce = 0.
  - Go to IDLE unconditionally; inputs are the same held request.
  - Load latency: 2 cycles, 1 stall cycle.
- IDLE, hit, store, req_be = 4'hF:
  - io_ce = 1, io_we = 1, io_wdata = req_wdata, req_stall = 0.
  - Single cycle; stay IDLE. Back-to-back full stores proceed one per cycle.
- IDLE, hit, store, req_be = 4'h0:
  - No-op: io_ce = 0, no stall, stay IDLE.
- IDLE, hit, store, partial req_be:
  - Cycle 1: io_ce = 1, io_we = 0, req_stall = 1.
  - At posedge, merge_q lane i <= req_be[i] ? req_wdata lane i : io_rdata lane i; go to RMW_WR.
- RMW_WR:
  - io_ce = 1, io_we = 1, io_wdata = merge_q, req_stall = 0; go to IDLE.
  - Partial-store latency: 2 cycles, 1 stall cycle.
- req_rdata outside RD_DONE is 32'h0.
- io_addr always mirrors req_addr (valid because the request is held during stall); io_wdata = 0 when io_we = 0.
- A request arriving the cycle after RD_DONE/RMW_WR is a new request and is treated normally from IDLE.
- No simultaneous-request case exists: single requester, one outstanding access.

Test Plan:
- Reset with req_ce = 1 to 0x4000, then release → io_ce = 0 and req_stall = 0 during reset; first request handled from IDLE.
- Full store 0x4008 ← 0xDEADBEEF, be = F, then load 0x4008 → store in 1 cycle with no stall; load stalls 1 cycle, then req_rdata = 0xDEADBEEF for exactly one cycle.
- IO word 0x4010 = 0x11223344; store 0x000000AA, be = 4'b0001; reload → 2-cycle RMW with io_we low then high; reload returns 0x112233AA.
- Access to 0x8000 (load and store) → io_ce stays 0, no stall, req_rdata = 0; IO contents unchanged.
- Store be = 0 to 0x4010 → no io_ce pulse, no stall, word unchanged.
- Partial store in progress; assert rst low during the stall cycle → state IDLE immediately, no io_we pulse, word unchanged after reset release.

Source files
------------

// File: rtl/io_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_bridge
// Purpose  : MEM-stage to word-addressed IO memory bridge; loads and partial
//            stores (read-modify-write) stall the pipeline for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_bridge #(
  parameter logic [31:0] IO_BASE = 32'h0000_4000,
  parameter logic [31:0] IO_MASK = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_ce,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_stall,
  output logic [31:0] req_rdata,
  output logic        io_ce,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_DONE = 2'd1;
  localparam logic [1:0] ST_RMW_WR  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;
  logic        hit;
  logic        be_full;
  logic        be_none;

  assign hit     = req_ce & ((req_addr & IO_MASK) == IO_BASE);
  assign be_full = (req_be == 4'hF);
  assign be_none = (req_be == 4'h0);
  // The request is held during a stall, so the address is always current.
  assign io_addr = req_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          if (!req_we) begin
            rdata_d = io_rdata;
            state_d = ST_RD_DONE;
          end else if (!be_full && !be_none) begin
            for (int i = 0; i < 4; i++) begin
              merge_d[8*i +: 8] = req_be[i] ? req_wdata[8*i +: 8] : io_rdata[8*i +: 8];
            end
            state_d = ST_RMW_WR;
          end
        end
      end
      ST_RD_DONE: state_d = ST_IDLE;
      ST_RMW_WR:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, whatever the request.
  always_comb begin
    io_ce     = 1'b0;
    io_we     = 1'b0;
    io_wdata  = 32'h0;
    req_stall = 1'b0;
    req_rdata = 32'h0;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            if (!req_we) begin
              io_ce     = 1'b1;
              req_stall = 1'b1;
            end else if (be_full) begin
              io_ce    = 1'b1;
              io_we    = 1'b1;
              io_wdata = req_wdata;
            end else if (!be_none) begin
              io_ce     = 1'b1;
              req_stall = 1'b1;
            end
          end
        end
        ST_RD_DONE: req_rdata = rdata_q;
        ST_RMW_WR: begin
          io_ce    = 1'b1;
          io_we    = 1'b1;
          io_wdata = merge_q;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bus_bridge
// Purpose  : Scoreboard bench for io_bus_bridge with a word-array IO memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_ce = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        req_stall;
  logic [31:0] req_rdata;
  logic        io_ce;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  io_bus_bridge dut (
    .clk(clk), .rst(rst),
    .req_ce(req_ce), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .req_stall(req_stall), .req_rdata(req_rdata),
    .io_ce(io_ce), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] iomem   [1024];
  logic [31:0] ref_mem [1024];

  assign io_rdata = iomem[io_addr[11:2]];

  always @(posedge clk) begin
    if (io_ce && io_we) iomem[io_addr[11:2]] <= io_wdata;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rd_q[$];
  logic [63:0] wr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes on every IO write and expected load data
  // on the cycle a load's stall drops.
  logic prev_stall = 1'b0;
  logic prev_load  = 1'b0;
  always @(negedge clk) begin
    logic [63:0] w;
    if (io_ce && io_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_io_write_addr", io_addr, 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        chk("io_write_addr", io_addr, w[63:32]);
        chk("io_write_data", io_wdata, w[31:0]);
      end
    end
    if (!io_we) chk("io_wdata_idle", io_wdata, 32'h0);
    if (rst && prev_stall && !req_stall && prev_load) begin
      if (rd_q.size() == 0) chk("unexpected_load_return", req_rdata, 32'hFFFF_FFFF);
      else chk("load_rdata", req_rdata, rd_q.pop_front());
    end else begin
      chk("rdata_idle", req_rdata, 32'h0);
    end
    prev_stall = rst && req_stall;
    prev_load  = req_ce && !req_we;
  end

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Reference: decides from the rules what the bus should do for one request,
  // queues the expected responses and updates the model memory.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    logic        hit;
    int          idx;
    logic [31:0] newv;
    logic        c1_ce, c1_we, c1_stall, two;
    hit = ((addr & 32'hFFFF_F000) == 32'h0000_4000);
    idx = int'(addr[11:2]);
    c1_ce = 0; c1_we = 0; c1_stall = 0; two = 0;
    if (hit && !we) begin
      rd_q.push_back(ref_mem[idx]);
      c1_ce = 1; c1_stall = 1; two = 1;
    end else if (hit && be == 4'hF) begin
      wr_q.push_back({addr, wdata});
      ref_mem[idx] = wdata;
      c1_ce = 1; c1_we = 1;
    end else if (hit && be != 4'h0) begin
      newv = (wdata & be_mask(be)) | (ref_mem[idx] & ~be_mask(be));
      wr_q.push_back({addr, newv});
      ref_mem[idx] = newv;
      c1_ce = 1; c1_stall = 1; two = 1;
    end
    req_ce = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(negedge clk);
    chk("c1_io_ce", {31'h0, io_ce}, {31'h0, c1_ce});
    chk("c1_io_we", {31'h0, io_we}, {31'h0, c1_we});
    chk("c1_stall", {31'h0, req_stall}, {31'h0, c1_stall});
    @(posedge clk); #1;
    if (two) begin
      @(negedge clk);
      chk("c2_stall", {31'h0, req_stall}, 32'h0);
      chk("c2_io_ce", {31'h0, io_ce}, {31'h0, we});
      chk("c2_io_we", {31'h0, io_we}, {31'h0, we});
      @(posedge clk); #1;
    end
    req_ce = 0;
  endtask

  initial begin
    logic [31:0] a;
    int          mismatches;
    for (int i = 0; i < 1024; i++) begin
      iomem[i]   = $urandom;
      ref_mem[i] = iomem[i];
    end

    // Reset held with a live in-window load presented.
    rst = 0; req_ce = 1; req_we = 0; req_addr = 32'h0000_4000; req_be = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_io_ce", {31'h0, io_ce}, 32'h0);
      chk("rst_stall", {31'h0, req_stall}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1;
    issue(0, 32'h0000_4000, 32'h0, 4'hF);

    issue(1, 32'h0000_4008, 32'hDEAD_BEEF, 4'hF);
    issue(0, 32'h0000_4008, 32'h0, 4'hF);

    iomem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
    issue(1, 32'h0000_4010, 32'h0000_00AA, 4'b0001);
    issue(0, 32'h0000_4010, 32'h0, 4'hF);

    issue(0, 32'h0000_8000, 32'h0, 4'hF);
    issue(1, 32'h0000_8000, 32'h5555_5555, 4'hF);
    issue(1, 32'h0000_4010, 32'hCAFE_F00D, 4'h0);
    issue(0, 32'h0000_4010, 32'h0, 4'hF);

    // Reset asserted during the stall cycle of a partial store.
    req_ce = 1; req_we = 1; req_addr = 32'h0000_4010; req_wdata = 32'h9999_9999; req_be = 4'b0110;
    @(negedge clk);
    chk("rmw_pre_rst_stall", {31'h0, req_stall}, 32'h1);
    #2 rst = 0;
    #1;
    chk("rmw_rst_io_ce", {31'h0, io_ce}, 32'h0);
    chk("rmw_rst_io_we", {31'h0, io_we}, 32'h0);
    chk("rmw_rst_stall", {31'h0, req_stall}, 32'h0);
    @(negedge clk);
    chk("rmw_rst_io_we2", {31'h0, io_we}, 32'h0);
    req_ce = 0;
    @(posedge clk); #1;
    rst = 1;
    chk("rmw_rst_word", iomem[4], ref_mem[4]);
    issue(0, 32'h0000_4010, 32'h0, 4'hF);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) a = $urandom;
      else a = 32'h0000_4000 | {20'h0, 2'($urandom_range(0, 3)), 10'($urandom), 2'($urandom)};
      if ($urandom_range(0, 3) == 0) a = 32'h0000_4000 | {22'h0, 4'($urandom), 2'b00, 2'($urandom)};
      issue(1'($urandom), a, $urandom, 4'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rd_q_left", rd_q.size(), 32'h0);
    chk("wr_q_left", wr_q.size(), 32'h0);
    mismatches = 0;
    for (int i = 0; i < 1024; i++) if (iomem[i] !== ref_mem[i]) mismatches++;
    chk("mem_words_differ", mismatches, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
